mat_vec_loader: RTL
===================

// Module: mat_vec_loader
// PURPOSE
//  Upstream feeder for the 8x8 matrix-vector MAC array. On a start pulse, fetches an
//  8x8 matrix A (one row per memory word) and vector B (one word) over an Avalon-MM-style
//  read master into an internal 8x8 byte buffer.
//  It then transposes the buffer into 8 column-wise write beats, driving the 8 A-row FIFOs
//  and the B FIFO in parallel (shared a_wren/b_wren), and pulses done.
// PARAMETERS
//  DATA_WIDTH  8   element width in bits
//  DIM         8   matrix dimension (rows = cols = vector length = FIFO count)
//  ADDR_WIDTH  32  memory word-address width
// PORTS
//  clk                clock    1                        single clock; all logic on posedge
//  rst                input    1                        synchronous, active-high reset
//  start              input    1                        begin load; sampled in IDLE only
//  base_addr          input    ADDR_WIDTH               word address of A row 0; latched on accepted start
//  busy               output   1                        high in any state other than IDLE
//  done               output   1                        one-cycle pulse after last write beat
//  mem_address        output   ADDR_WIDTH               read word address
//  mem_read           output   1                        read request
//  mem_waitrequest    input    1                        slave stall; request accepted when mem_read & !mem_waitrequest
//  mem_readdata       input    DIM*DATA_WIDTH           read word; byte j = bits [8j+7:8j] = element j
//  mem_readdatavalid  input    1                        mem_readdata valid this cycle
//  fifo_full          input    1                        OR of all A-FIFO full and B-FIFO full flags
//  a_wren             output   1                        write strobe to all DIM A FIFOs
//  b_wren             output   1                        write strobe to the B FIFO (identical to a_wren)
//  a_fifo_in[DIM-1:0] output   DATA_WIDTH each          a_fifo_in[i] = A[i][col]
//  b_fifo_in          output   DATA_WIDTH               B[col]
// BEHAVIOUR
//  - Reset (sync, rst=1): state IDLE; row index, column counter, latched address and buffer
//    cleared to 0. All outputs 0 the cycle after rst is sampled. Reset mid-operation aborts
//    immediately: no further reads or writes, and no done pulse.
//  - FSM states: IDLE, REQ, WAIT, PUSH, DONE.
//  - IDLE: start=1 -> latch base_addr, row=0, go to REQ.
//  - REQ: mem_read=1, mem_address = base + row. Hold both stable while mem_waitrequest=1.
//    On acceptance, go to WAIT. At most one read is outstanding at any time.
//  - WAIT: mem_read=0. On mem_readdatavalid, store the word:
//    - rows 0..DIM-1 go to buffer row `row`; row DIM goes to the B register.
//    - If row<DIM, increment row and go to REQ; otherwise col=0 and go to PUSH.
//  - PUSH: a_wren = b_wren = !fifo_full (combinational from fifo_full; all other outputs
//    come from registers).
//    - Data outputs show column col.
//    - Beat taken: col increments. When fifo_full=1, col holds and data stays stable.
//    - After the beat with col=DIM-1, go to DONE.
//  - DONE: done=1 for exactly one cycle, then IDLE. busy=0 in the IDLE cycle.
//  - mem_readdatavalid outside WAIT is ignored. start while busy is ignored (not queued).
//  - Totals: DIM+1 reads at addresses base..base+DIM, then exactly DIM write beats.
//    Address arithmetic wraps modulo 2^ADDR_WIDTH.
//  - Minimum latency, zero-wait memory with readdatavalid 1 cycle after accept:
//    - start cycle t: REQ at t+1.
//    - Reads: 2 cycles per word (18 cycles).
//    - Write beats: 8 cycles.
//    - done at t+27.
// TESTING
//  1 Reset: hold rst 2 cycles -> busy, done, mem_read, a_wren, b_wren = 0; all data outputs 0.
//  2 Basic load, base=0x100, A[r][j]=16r+j, B[j]=0x80+j, zero wait ->
//    - reads at 0x100..0x108;
//    - 8 beats, beat j: a_fifo_in[i]=16i+j, b_fifo_in=0x80+j;
//    - done at t+27.
//  3 mem_waitrequest=1 for 3 cycles on address 0x102 -> mem_read/mem_address held at 0x102;
//    exactly 9 reads total; data still correct.
//  4 fifo_full=1 for 4 cycles at column 3 -> a_wren=0 those cycles, outputs hold column 3;
//    beat 3 is written once after release; 8 beats total.
//  5 start pulsed during WAIT with base_addr=0x500 -> ignored; addresses stay 0x100-based;
//    a single done pulse.
//  6 rst asserted during PUSH at column 5 -> next cycle IDLE, a_wren=0, no done;
//    a new start then completes a full, correct load.

Source files
------------

// File: rtl/mat_vec_loader.sv
// Feeder for the 8x8 MAC array. Reads matrix A one row per word, then vector
// B, into a local byte buffer. It then replays the buffer column by column
// into the A-row FIFOs and the B FIFO.
//
// state  | meaning
// S_IDLE | waiting for start; base address latched on accept
// S_REQ  | read request for word `row` outstanding on the bus
// S_WAIT | request accepted, waiting for readdatavalid
// S_PUSH | one column per beat to the FIFOs, stalls on fifo_full
// S_DONE | one-cycle done pulse
module mat_vec_loader #(
   parameter int DATA_WIDTH = 8,
   parameter int DIM        = 8,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [ADDR_WIDTH-1:0]     base_addr,
   output logic                      busy,
   output logic                      done,
   output logic [ADDR_WIDTH-1:0]     mem_address,
   output logic                      mem_read,
   input  logic                      mem_waitrequest,
   input  logic [DIM*DATA_WIDTH-1:0] mem_readdata,
   input  logic                      mem_readdatavalid,
   input  logic                      fifo_full,
   output logic                      a_wren,
   output logic                      b_wren,
   output logic [DATA_WIDTH-1:0]     a_fifo_in [DIM],
   output logic [DATA_WIDTH-1:0]     b_fifo_in
);

   localparam int ROW_W = $clog2(DIM + 1);
   localparam int COL_W = (DIM > 1) ? $clog2(DIM) : 1;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_PUSH, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [ROW_W-1:0]        row_q;
   logic [COL_W-1:0]        col_q;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic [DATA_WIDTH-1:0]   mat_buf [DIM][DIM];
   logic [DATA_WIDTH-1:0]   b_buf [DIM];
   logic                    row_last;
   logic                    col_last;

   // Row DIM is the extra word that carries vector B.
   assign row_last = (row_q == ROW_W'(DIM));
   assign col_last = (col_q == COL_W'(DIM - 1));

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_REQ;
         S_REQ:  if (!mem_waitrequest) state_d = S_WAIT;
         S_WAIT: if (mem_readdatavalid) state_d = row_last ? S_PUSH : S_REQ;
         S_PUSH: if (!fifo_full && col_last) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, counters, latched address and the read buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         base_q  <= '0;
         for (int i = 0; i < DIM; i++) begin
            b_buf[i] <= '0;
            for (int j = 0; j < DIM; j++) mat_buf[i][j] <= '0;
         end
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  base_q <= base_addr;
                  row_q  <= '0;
               end
            end
            S_WAIT: begin
               if (mem_readdatavalid) begin
                  if (row_last) begin
                     for (int j = 0; j < DIM; j++)
                        b_buf[j] <= mem_readdata[j*DATA_WIDTH +: DATA_WIDTH];
                     col_q <= '0;
                  end else begin
                     for (int j = 0; j < DIM; j++)
                        mat_buf[row_q[COL_W-1:0]][j] <= mem_readdata[j*DATA_WIDTH +: DATA_WIDTH];
                     row_q <= row_q + 1'b1;
                  end
               end
            end
            S_PUSH: begin
               if (!fifo_full) col_q <= col_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Column transpose: FIFO i gets A[i][col]; the B FIFO gets B[col].
   always_comb begin
      for (int i = 0; i < DIM; i++) a_fifo_in[i] = mat_buf[i][col_q];
      b_fifo_in = b_buf[col_q];
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign mem_read    = (state_q == S_REQ);
   assign mem_address = base_q + ADDR_WIDTH'(row_q);
   assign a_wren      = (state_q == S_PUSH) && !fifo_full;
   assign b_wren      = a_wren;

endmodule
